// File: rtl/run_controller.sv
// Multi-cycle execution sequencer: steps the accumulator core through EXEC, memory waits and debug single-step.
// Optional memory watchdog enabled by defining RUN_CONTROLLER_MEM_TIMEOUT_EN.
module run_controller #(
  parameter int PC_WIDTH       = 12,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic                   step_mode,
  input  logic                   step,
  input  logic                   halt_decoded,
  input  logic                   mem_access,
  input  logic                   mem_write,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   pc_reset,
  output logic                   pc_enable,
  output logic                   commit,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  generate
    if (PC_WIDTH < 1 || COUNT_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("run_controller: widths and TIMEOUT_CYCLES must be positive");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MEM_WAIT, S_STEP_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t                 state_reg;
  logic                   store_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [COUNT_WIDTH-1:0] cycle_count_reg;
  logic [COUNT_WIDTH-1:0] instr_count_reg;
  logic                   timeout_hit;

`ifdef RUN_CONTROLLER_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_count_reg;
  logic              error_reg;

  assign timeout_hit = (state_reg == S_MEM_WAIT) && !mem_ack &&
                       (wait_count_reg == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign error       = error_reg;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // Handshake outputs are combinational so the PC and write-back see them in the same cycle.
  always_comb begin
    pc_reset = 1'b0;
    commit   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    if (reset_n) begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: pc_reset = req;
        S_EXEC: begin
          if (!halt_decoded) begin
            if (mem_access) begin
              mem_req = 1'b1;
              mem_we  = mem_write;
              commit  = mem_ack;
            end else begin
              commit = 1'b1;
            end
          end
        end
        S_MEM_WAIT: begin
          mem_req = 1'b1;
          mem_we  = store_reg;
          commit  = mem_ack;
        end
        default: ;
      endcase
    end
    pc_enable = commit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      store_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cycle_count_reg <= '0;
      instr_count_reg <= '0;
`ifdef RUN_CONTROLLER_MEM_TIMEOUT_EN
      wait_count_reg  <= '0;
      error_reg       <= 1'b0;
`endif
    end else begin
      if (busy_reg && cycle_count_reg != '1)
        cycle_count_reg <= cycle_count_reg + COUNT_WIDTH'(1);
      if (commit && instr_count_reg != '1)
        instr_count_reg <= instr_count_reg + COUNT_WIDTH'(1);

      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (req) begin
            state_reg       <= step_mode ? S_STEP_WAIT : S_EXEC;
            busy_reg        <= 1'b1;
            done_reg        <= 1'b0;
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
`ifdef RUN_CONTROLLER_MEM_TIMEOUT_EN
            error_reg       <= 1'b0;
`endif
          end
        end
        S_EXEC: begin
          if (halt_decoded) begin
            state_reg <= S_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (mem_access && !mem_ack) begin
            state_reg <= S_MEM_WAIT;
            store_reg <= mem_write;
`ifdef RUN_CONTROLLER_MEM_TIMEOUT_EN
            wait_count_reg <= '0;
`endif
          end else begin
            state_reg <= step_mode ? S_STEP_WAIT : S_EXEC;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            state_reg <= step_mode ? S_STEP_WAIT : S_EXEC;
          end else if (timeout_hit) begin
            state_reg <= S_ERROR;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`ifdef RUN_CONTROLLER_MEM_TIMEOUT_EN
            error_reg <= 1'b1;
          end else begin
            wait_count_reg <= wait_count_reg + WAIT_W'(1);
`endif
          end
        end
        S_STEP_WAIT: begin
          if (step || !step_mode)
            state_reg <= S_EXEC;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign cycle_count = cycle_count_reg;
  assign instr_count = instr_count_reg;

endmodule

// File: doc/run_controller.md
# run_controller

Parametrised execution sequencer for the accumulator core. It supersedes the single-cycle req/done control path with a multi-cycle FSM. The FSM stalls on a variable-latency data-memory handshake and supports a single-step debug mode. It also keeps saturating cycle and instruction counters. It sits between the instruction decoder and the program counter and gates every architectural write through `commit`.

## Interface
- `PC_WIDTH`, 12, width of the program counter (informational; no PC held here)
- `COUNT_WIDTH`, 16, width of `cycle_count` and `instr_count`
- `TIMEOUT_CYCLES`, 64, MEM_WAIT watchdog limit in cycles (used only with `RUN_CONTROLLER_MEM_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req`  in  1  start request; restarts execution from PC 0
- `step_mode`  in  1  1 = single-step: one instruction per `step` pulse
- `step`  in  1  single-step advance strobe
- `halt_decoded`  in  1  decoder: current instruction is halt
- `mem_access`  in  1  decoder: current instruction uses data memory
- `mem_write`  in  1  decoder: that access is a store
- `mem_ack`  in  1  data memory: access complete this cycle
- `mem_req`  out  1  data-memory request, held until ack
- `mem_we`  out  1  store qualifier, valid while `mem_req`=1
- `pc_reset`  out  1  force PC to 0
- `pc_enable`  out  1  advance PC
- `commit`  out  1  enable reg/acc/memory write-back for current instruction
- `busy`  out  1  state is EXEC, MEM_WAIT or STEP_WAIT
- `done`  out  1  execution finished (halt or error)
- `error`  out  1  memory timeout occurred
- `cycle_count`  out  COUNT_WIDTH  active cycles since last start
- `instr_count`  out  COUNT_WIDTH  committed instructions since last start

## Operation
- States: IDLE, EXEC, MEM_WAIT, STEP_WAIT, DONE, ERROR (ERROR only with macro). State is registered.
- Reset (`reset_n`=0 at edge) → IDLE, counters 0.
  - While `reset_n`=0, all combinational outputs are forced 0 in the same cycle.
  - Every output is 0 after reset.
- IDLE/DONE/ERROR with `req`=1:
  - `pc_reset`=1 that cycle; counters cleared and `error` cleared at the edge.
  - Next state EXEC if `step_mode`=0, else STEP_WAIT.
- EXEC, priority order:
  - `halt_decoded` → DONE. No commit, no `pc_enable`.
  - `mem_access`: `mem_req`=1, `mem_we`=`mem_write`.
    - If `mem_ack` is also 1 (zero-wait), commit as for a plain instruction.
    - Otherwise go to MEM_WAIT.
  - Otherwise `commit`=`pc_enable`=1 and `instr_count`++. Next state EXEC (`step_mode`=0) or STEP_WAIT (`step_mode`=1).
- MEM_WAIT:
  - `mem_req` held 1 and `mem_we` held from the registered store flag. Decoder inputs are ignored.
  - On `mem_ack`: `commit`=`pc_enable`=1, `instr_count`++, leave as from EXEC.
- STEP_WAIT:
  - Leave to EXEC on `step`=1 or `step_mode`=0. No outputs active except `busy`.
- DONE: `done`=1 held until `req`.
- `req` in EXEC/MEM_WAIT/STEP_WAIT is ignored.
- `mem_ack` outside MEM_WAIT/zero-wait EXEC is ignored.
- `cycle_count` increments each cycle `busy`=1. Both counters saturate at all-ones (no wrap).

## Timing
- `pc_reset`, `pc_enable`, `commit`, `mem_req`, `mem_we` are combinational from state and inputs; each is a single-cycle pulse except `mem_req`.
- `done`, `busy`, `error` and the counters are registered.
  - Halt seen in EXEC at cycle N → `done`=1 from N+1.
- Memory instruction latency: 1 + (cycles until `mem_ack`). Zero-wait access takes 1 cycle.
- `mem_req` never drops before `mem_ack` except on reset or timeout.

## Configuration
- `RUN_CONTROLLER_MEM_TIMEOUT_EN` defined:
  - A wait counter runs in MEM_WAIT.
  - After `TIMEOUT_CYCLES` cycles without `mem_ack`, the FSM moves to ERROR.
  - `mem_req` drops, and `error`=`done`=1 from the next cycle.
  - No commit for the timed-out instruction.
- Undefined: no wait counter, MEM_WAIT waits indefinitely, and `error` is tied 0.

## Test plan
- Reset, `req` pulse, three plain instructions then halt:
  - `pc_reset` 1 cycle.
  - `pc_enable`/`commit` on 3 consecutive cycles.
  - `done` rises the cycle after halt.
  - `instr_count`=3, `cycle_count`=4.
- Load with `mem_ack` 2 cycles after request:
  - `mem_req` high 3 cycles and `mem_we`=0.
  - Single `commit`/`pc_enable` on the ack cycle; `instr_count`=1.
- Zero-wait store (`mem_ack`=1 in EXEC): `mem_we`=1, commit same cycle, state stays EXEC.
- `step_mode`=1, two instructions, `step` pulses 5 cycles apart:
  - Exactly one commit per pulse.
  - `busy`=1 throughout; `cycle_count` counts the wait cycles.
- `reset_n`=0 during MEM_WAIT:
  - `mem_req` drops in the same cycle; IDLE next.
  - `done`=0, counters 0; a late `mem_ack` is ignored.
- With macro, `TIMEOUT_CYCLES`=4, no ack:
  - ERROR after 4 MEM_WAIT cycles, `error`=`done`=1, no commit.
  - A following `req` clears `error` and restarts at PC 0.
